regfile_mp: RTL and testbench

- Parametrised successor to the single-write, two-read CPU register file.
- Generalised width, depth and read-port count; two byte-enabled write ports with fixed priority; optional write-to-read bypass.
- Adds a per-register busy scoreboard for pending writes, used by the pipelined core's hazard logic.
- Sits between the decode stage (reads, busy marks) and the writeback stages (two commit ports).

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/rf_scoreboard.sv | 61 ++++++
 rtl/regfile_mp.sv | 105 ++++++++++
 tb/tb_regfile_mp.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizing and the
// per-byte write-merge rule used by both the commit path and the read bypass.
// Ports: none (package).
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NBYTES     = DATA_W_DEF / 8;

  // Merge one byte lane: port 1 beats port 0, otherwise the old byte survives.
  // en0/en1 are already qualified by address match and zero-register masking.
  function automatic logic [7:0] merge_byte(
    input logic [7:0] old_b,
    input logic [7:0] data0,
    input logic       be0,
    input logic       en0,
    input logic [7:0] data1,
    input logic       be1,
    input logic       en1
  );
    logic [7:0] r;
    r = old_b;
    if (en0 && be0) r = data0;
    if (en1 && be1) r = data1;
    return r;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: a mark sets a bit, a commit clears it; mark wins.
// Ports: clk/rst, mark_en/mark_addr, two clear ports (commits), NUM_RD lookup
// ports (raddr -> rbusy) with optional same-cycle clear forwarding, any_busy.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int NUM_RD   = 2,
  parameter int FWD      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  input  logic                     clr0_en,
  input  logic [ADDR_W-1:0]        clr0_addr,
  input  logic                     clr1_en,
  input  logic [ADDR_W-1:0]        clr1_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        rbusy,
  output logic                     any_busy
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0] busy;

  // Entry 0 can never be marked when it is the hardwired zero register,
  // so it always looks free without any extra masking on the read side.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (mark_en && mark_addr == ADDR_W'(r) && !(ZERO_REG != 0 && r == 0))
          busy[r] <= 1'b1;
        else if ((clr0_en && clr0_addr == ADDR_W'(r)) ||
                 (clr1_en && clr1_addr == ADDR_W'(r)))
          busy[r] <= 1'b0;
      end
    end
  end

  assign any_busy = |busy;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_look
    logic [ADDR_W-1:0] a;
    logic              b;
    assign a = raddr[i*ADDR_W +: ADDR_W];
    // Forward this cycle's clears only; this cycle's marks become visible next cycle.
    always_comb begin
      b = busy[a];
      if (FWD != 0 && !rst &&
          ((clr0_en && clr0_addr == a) || (clr1_en && clr1_addr == a)))
        b = 1'b0;
    end
    assign rbusy[i] = b;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two byte-enabled write
// ports (w1 beats w0 per byte), optional write-to-read bypass, busy scoreboard.
// Ports: clk/rst, raddr/rdata/rbusy, w0_* and w1_* commit ports, mark_en/mark_addr, any_busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     w0_en,
  input  logic [ADDR_W-1:0]        w0_addr,
  input  logic [DATA_W/8-1:0]      w0_be,
  input  logic [DATA_W-1:0]        w0_data,
  input  logic                     w1_en,
  input  logic [ADDR_W-1:0]        w1_addr,
  input  logic [DATA_W/8-1:0]      w1_be,
  input  logic [DATA_W-1:0]        w1_data,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  output logic                     any_busy
);

  localparam int NB    = DATA_W / 8;
  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];

  // Write enables with the zero register filtered out; these also drive the
  // scoreboard clears, so an all-zero byte enable still counts as a commit.
  logic w0_ok, w1_ok;
  assign w0_ok = w0_en && !(ZERO_REG != 0 && w0_addr == '0);
  assign w1_ok = w1_en && !(ZERO_REG != 0 && w1_addr == '0);

  function automatic logic [DATA_W-1:0] merge_word(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] d0,
    input logic [NB-1:0]     be0,
    input logic              h0,
    input logic [DATA_W-1:0] d1,
    input logic [NB-1:0]     be1,
    input logic              h1
  );
    logic [DATA_W-1:0] r;
    for (int b = 0; b < NB; b++)
      r[b*8 +: 8] = merge_byte(old_w[b*8 +: 8], d0[b*8 +: 8], be0[b], h0,
                               d1[b*8 +: 8], be1[b], h1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if ((w0_ok && w0_addr == ADDR_W'(r)) || (w1_ok && w1_addr == ADDR_W'(r)))
          mem[r] <= merge_word(mem[r], w0_data, w0_be, w0_ok && w0_addr == ADDR_W'(r),
                               w1_data, w1_be, w1_ok && w1_addr == ADDR_W'(r));
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] word;
    assign a = raddr[i*ADDR_W +: ADDR_W];
    always_comb begin
      word = mem[a];
      // Bypass shows the value the entry will hold after this edge.
      if (BYPASS != 0 && !rst)
        word = merge_word(mem[a], w0_data, w0_be, w0_ok && w0_addr == a,
                          w1_data, w1_be, w1_ok && w1_addr == a);
      if (ZERO_REG != 0 && a == '0)
        word = '0;
    end
    assign rdata[i*DATA_W +: DATA_W] = word;
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .NUM_RD  (NUM_RD),
    .FWD     (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .mark_en  (mark_en),
    .mark_addr(mark_addr),
    .clr0_en  (w0_ok),
    .clr0_addr(w0_addr),
    .clr1_en  (w1_ok),
    .clr1_addr(w1_addr),
    .raddr    (raddr),
    .rbusy    (rbusy),
    .any_busy (any_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance
// share the same stimulus; expected values are hand-computed constants.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd0, rd1;
  logic [9:0]  raddr;
  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic        w0_en, w1_en, mark_en;
  logic [4:0]  w0_addr, w1_addr, mark_addr;
  logic [3:0]  w0_be, w1_be;
  logic [31:0] w0_data, w1_data;
  logic        any_b, any_n;

  int checks   = 0;
  int failures = 0;

  assign raddr = {rd1, rd0};

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_be(w0_be), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_be(w1_be), .w1_data(w1_data),
    .mark_en(mark_en), .mark_addr(mark_addr), .any_busy(any_b));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_be(w0_be), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_be(w1_be), .w1_data(w1_data),
    .mark_en(mark_en), .mark_addr(mark_addr), .any_busy(any_n));

  // Advance one edge; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w0_en = 0; w0_addr = '0; w0_be = '0; w0_data = '0;
    w1_en = 0; w1_addr = '0; w1_be = '0; w1_data = '0;
    mark_en = 0; mark_addr = '0;
  endtask

  task automatic test_reset();
    idle(); rd0 = 5; rd1 = 0;
    w0_en = 1; w0_addr = 5; w0_be = 4'hF; w0_data = 32'hDEADBEEF;
    mark_en = 1; mark_addr = 5;
    step(); idle(); #1;
    checks++; if (rdata_b[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL preload_r5 got=%h exp=%h", rdata_b[31:0], 32'hDEADBEEF); end
    checks++; if (rbusy_b[0] !== 1'b1) begin failures++; $display("FAIL preload_busy got=%b exp=1", rbusy_b[0]); end
    checks++; if (any_b !== 1'b1) begin failures++; $display("FAIL preload_any got=%b exp=1", any_b); end
    // During reset, bypass is suppressed even with a write in flight.
    rst = 1; w0_en = 1; w0_addr = 5; w0_be = 4'hF; w0_data = 32'h12345678; #1;
    checks++; if (rdata_b[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL rst_no_bypass got=%h exp=%h", rdata_b[31:0], 32'hDEADBEEF); end
    step(); rst = 0; idle(); #1;
    checks++; if (rdata_b[31:0] !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", rdata_b[31:0]); end
    checks++; if (rbusy_b[0] !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", rbusy_b[0]); end
    checks++; if (any_b !== 1'b0 || any_n !== 1'b0) begin failures++; $display("FAIL rst_any got=%b/%b exp=0/0", any_b, any_n); end
  endtask

  task automatic test_priority();
    idle(); rd0 = 3;
    w1_en = 1; w1_addr = 3; w1_be = 4'hF; w1_data = 32'h11223344;
    step(); idle();
    w0_en = 1; w0_addr = 3; w0_be = 4'b1111; w0_data = 32'hAAAAAAAA;
    w1_en = 1; w1_addr = 3; w1_be = 4'b0011; w1_data = 32'h0000BBCC; #1;
    checks++; if (rdata_b[31:0] !== 32'hAAAABBCC) begin failures++; $display("FAIL prio_bypass got=%h exp=%h", rdata_b[31:0], 32'hAAAABBCC); end
    checks++; if (rdata_n[31:0] !== 32'h11223344) begin failures++; $display("FAIL prio_nobypass got=%h exp=%h", rdata_n[31:0], 32'h11223344); end
    step(); idle(); #1;
    checks++; if (rdata_b[31:0] !== 32'hAAAABBCC || rdata_n[31:0] !== 32'hAAAABBCC) begin failures++; $display("FAIL prio_commit got=%h/%h exp=%h", rdata_b[31:0], rdata_n[31:0], 32'hAAAABBCC); end
  endtask

  task automatic test_independent();
    idle(); rd0 = 10; rd1 = 11;
    w0_en = 1; w0_addr = 10; w0_be = 4'b0011; w0_data = 32'hFFFF5566;
    w1_en = 1; w1_addr = 11; w1_be = 4'b1100; w1_data = 32'h7788FFFF;
    step(); idle(); #1;
    checks++; if (rdata_n[31:0] !== 32'h00005566) begin failures++; $display("FAIL indep_w0 got=%h exp=%h", rdata_n[31:0], 32'h00005566); end
    checks++; if (rdata_n[63:32] !== 32'h77880000) begin failures++; $display("FAIL indep_w1 got=%h exp=%h", rdata_n[63:32], 32'h77880000); end
  endtask

  task automatic test_bypass();
    idle(); rd0 = 0; rd1 = 7;
    w0_en = 1; w0_addr = 7; w0_be = 4'hF; w0_data = 32'h01020304;
    step(); idle();
    w0_en = 1; w0_addr = 7; w0_be = 4'b0100; w0_data = 32'h00FF0000; #1;
    checks++; if (rdata_b[63:32] !== 32'h01FF0304) begin failures++; $display("FAIL byp_on got=%h exp=%h", rdata_b[63:32], 32'h01FF0304); end
    checks++; if (rdata_n[63:32] !== 32'h01020304) begin failures++; $display("FAIL byp_off got=%h exp=%h", rdata_n[63:32], 32'h01020304); end
    step(); idle(); #1;
    checks++; if (rdata_n[63:32] !== 32'h01FF0304) begin failures++; $display("FAIL byp_off_after got=%h exp=%h", rdata_n[63:32], 32'h01FF0304); end
  endtask

  task automatic test_zero();
    idle(); rd0 = 0; rd1 = 0;
    w1_en = 1; w1_addr = 0; w1_be = 4'hF; w1_data = 32'h12345678;
    mark_en = 1; mark_addr = 0; #1;
    checks++; if (rdata_b[31:0] !== 32'h0) begin failures++; $display("FAIL zero_bypass got=%h exp=0", rdata_b[31:0]); end
    step(); idle(); #1;
    checks++; if (rdata_b[31:0] !== 32'h0 || rdata_n[31:0] !== 32'h0) begin failures++; $display("FAIL zero_data got=%h/%h exp=0", rdata_b[31:0], rdata_n[31:0]); end
    checks++; if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b/%b exp=0", rbusy_b[0], rbusy_n[0]); end
    checks++; if (any_b !== 1'b0) begin failures++; $display("FAIL zero_any got=%b exp=0", any_b); end
  endtask

  task automatic test_scoreboard();
    idle(); rd0 = 9;
    mark_en = 1; mark_addr = 9; #1;
    checks++; if (rbusy_b[0] !== 1'b0) begin failures++; $display("FAIL sb_mark_not_fwd got=%b exp=0", rbusy_b[0]); end
    step();   // t+1: repeat the mark, must stay set without any counting
    checks++; if (rbusy_b[0] !== 1'b1 || rbusy_n[0] !== 1'b1) begin failures++; $display("FAIL sb_t1 got=%b/%b exp=1", rbusy_b[0], rbusy_n[0]); end
    step(); idle();   // t+2
    checks++; if (any_b !== 1'b1) begin failures++; $display("FAIL sb_any_t2 got=%b exp=1", any_b); end
    step();   // t+3: commit with no byte enables
    w0_en = 1; w0_addr = 9; w0_be = 4'b0000; w0_data = 32'hFFFFFFFF; #1;
    checks++; if (rbusy_b[0] !== 1'b0) begin failures++; $display("FAIL sb_clr_fwd got=%b exp=0", rbusy_b[0]); end
    checks++; if (rbusy_n[0] !== 1'b1) begin failures++; $display("FAIL sb_clr_nofwd got=%b exp=1", rbusy_n[0]); end
    checks++; if (any_b !== 1'b1) begin failures++; $display("FAIL sb_any_t3 got=%b exp=1", any_b); end
    step(); idle(); #1;   // t+4
    checks++; if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b0) begin failures++; $display("FAIL sb_t4 got=%b/%b exp=0", rbusy_b[0], rbusy_n[0]); end
    checks++; if (any_b !== 1'b0 || any_n !== 1'b0) begin failures++; $display("FAIL sb_any_t4 got=%b/%b exp=0", any_b, any_n); end
    checks++; if (rdata_n[31:0] !== 32'h0) begin failures++; $display("FAIL sb_be0_data got=%h exp=0", rdata_n[31:0]); end
  endtask

  task automatic test_mark_commit();
    idle(); rd0 = 4;
    mark_en = 1; mark_addr = 4;
    step(); idle();
    mark_en = 1; mark_addr = 4;
    w1_en = 1; w1_addr = 4; w1_be = 4'hF; w1_data = 32'hCAFEF00D; #1;
    checks++; if (rbusy_b[0] !== 1'b0) begin failures++; $display("FAIL mc_fwd_busy got=%b exp=0", rbusy_b[0]); end
    checks++; if (rbusy_n[0] !== 1'b1) begin failures++; $display("FAIL mc_nofwd_busy got=%b exp=1", rbusy_n[0]); end
    step(); idle(); #1;
    checks++; if (rbusy_b[0] !== 1'b1 || rbusy_n[0] !== 1'b1) begin failures++; $display("FAIL mc_busy_after got=%b/%b exp=1", rbusy_b[0], rbusy_n[0]); end
    checks++; if (rdata_b[31:0] !== 32'hCAFEF00D) begin failures++; $display("FAIL mc_data got=%h exp=%h", rdata_b[31:0], 32'hCAFEF00D); end
    checks++; if (any_b !== 1'b1) begin failures++; $display("FAIL mc_any got=%b exp=1", any_b); end
  endtask

  initial begin
    rst = 1; rd0 = 0; rd1 = 0; idle();
    step(); step();
    rst = 0;
    test_reset();
    test_priority();
    test_independent();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_mark_commit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
